spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
Shares one spi_ram instance between NUM_REQ requesters with round-robin arbitration. Each requester issues a single-beat read or write (addr, wdata, we). The block converts it into the RAM's two-beat 10-bit command protocol on din/rx_valid, collects read data from tx_valid/dout, and returns a per-requester response. It sits between the internal masters and spi_ram, replacing direct SPI-slave drive of the RAM in system configurations.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_SIZE, 8, RAM address width; din payload is 8 bits
RD_TIMEOUT, 16, cycles to wait for tx_valid after a read-data beat before flagging an error

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  request per requester; held with its payload until its gnt
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*8  flattened addresses, requester i at [8i+7:8i]
req_wdata  in  NUM_REQ*8  flattened write data
gnt  out  NUM_REQ  one-cycle pulse: request accepted, payload captured
rsp_valid  out  NUM_REQ  one-cycle pulse: transaction complete
rsp_rdata  out  8  read data, valid with rsp_valid
rsp_err  out  1  read timeout, valid with rsp_valid
busy  out  1  high whenever state != IDLE
ram_din  out  10  to spi_ram din
ram_rx_valid  out  1  to spi_ram rx_valid
ram_tx_valid  in  1  from spi_ram tx_valid
ram_dout  in  8  from spi_ram dout

Behaviour:
- Command codes on ram_din[9:8]: 00 write-address, 01 write-data, 10 read-address, 11 read-data (payload 8'h00).
- Every output is registered. On reset all outputs are 0, state is IDLE, and the RR pointer is 0.
- FSM states: IDLE, ADDR, DATA, WAIT_RD, RESP.
- IDLE: if any req is high at an edge, the winner is the first requester at or after the pointer, in increasing index with wrap. At that edge:
  - latch the winner's we, addr and wdata;
  - the next cycle shows gnt[winner]=1, ram_din={we?00:10, addr}, ram_rx_valid=1;
  - go to ADDR.
  If no req is high, stay in IDLE with ram_rx_valid=0.
- ADDR (1 cycle): next cycle shows ram_din={01,wdata} for a write or {11,8'h00} for a read, ram_rx_valid=1. Go to DATA.
- DATA (1 cycle): ram_rx_valid drops to 0 next cycle.
  - Write: go to RESP.
  - Read: go to WAIT_RD and clear the timeout counter.
- WAIT_RD:
  - On ram_tx_valid=1: capture ram_dout into rsp_rdata, set rsp_err=0, go to RESP.
  - If the counter reaches RD_TIMEOUT-1 without ram_tx_valid: rsp_rdata=8'h00, rsp_err=1, go to RESP.
- RESP (1 cycle): rsp_valid[winner]=1, pointer = (winner+1) mod NUM_REQ, go to IDLE. rsp_rdata and rsp_err hold until the next RESP.
- Latency:
  - write: gnt at T+1, beats at T+1 and T+2, rsp_valid at T+3 (T = sampling edge);
  - read: rsp_valid one cycle after the tx_valid cycle.
- Back-to-back: a new request can be sampled on the edge leaving RESP's cycle, so at most 1 idle cycle on ram_rx_valid between transactions.
- req is ignored outside IDLE. A requester that drops req before gnt is not served.
- ram_tx_valid outside WAIT_RD is ignored and does not affect the timeout counter.
- Reset mid-transaction:
  - all state is cleared and no rsp_valid is produced for the aborted request;
  - the RAM shares rst_n, so a partially written address is discarded.
- Pointer update happens only in RESP, including error responses.

Decomposition:
- Package spi_ram_pkg:
  - cmd_t enum (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11);
  - arb_state_t enum;
  - DATA_W=8, DIN_W=10.
- Sub-module rr_arbiter (NUM_REQ): combinational winner index and one-hot from req and pointer. Pointer register stays in the parent.

Test Plan:
- req[0] write addr 8'h12 data 8'hA5 after reset -> gnt[0] at T+1; ram_din 10'h012 then 10'h1A5 on consecutive cycles with ram_rx_valid=1; rsp_valid[0] at T+3.
- req[0] read addr 8'h12, RAM model returns 8'hA5 with tx_valid -> ram_din 10'h212 then 10'h300; rsp_rdata=8'hA5, rsp_err=0, rsp_valid[0].
- req[0] and req[1] both held continuously for 4 transactions after reset -> grant order 0,1,0,1; ram_rx_valid low for exactly 1 cycle between writes.
- Read with ram_tx_valid never asserted, RD_TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_rdata=8'h00, 16 cycles after WAIT_RD entry; next request served normally.
- rst_n pulsed low in WAIT_RD -> all outputs 0 immediately; no rsp_valid; pointer=0; next request granted to requester 0.
- Stray ram_tx_valid in IDLE with dout=8'hFF -> no rsp_valid, rsp_rdata unchanged.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and widths for the spi_ram arbiter
package spi_ram_pkg;

    localparam int DATA_W = 8;
    localparam int DIN_W  = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_RD,
        RESP
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import spi_ram_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic [NUM_REQ-1:0] onehot,
    output logic               valid
);

    logic [IW-1:0] j;

    // scan offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
        onehot = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sharing of one spi_ram across single-beat requesters
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [DIN_W-1:0]          ram_din,
    output logic                      ram_rx_valid,
    input  logic                      ram_tx_valid,
    input  logic [DATA_W-1:0]         ram_dout
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    arb_state_t state, state_n;
    logic [IW-1:0] ptr, ptr_n, win, win_n, arb_ptr, arb_idx, ptr_inc;
    logic [NUM_REQ-1:0] arb_oh, win_oh, gnt_n, rsp_valid_n;
    logic arb_any, we_q, we_n, rsp_err_n, rx_valid_n;
    logic [DATA_W-1:0] wdata_q, wdata_n, rsp_rdata_n;
    logic [ADDR_SIZE-1:0] req_a;
    logic [DIN_W-1:0] din_n;
    logic [CW-1:0] cnt, cnt_n;

    assign ptr_inc = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign arb_ptr = (state == RESP) ? ptr_inc : ptr;
    assign win_oh  = NUM_REQ'(1) << win;
    assign req_a   = req_addr[arb_idx*ADDR_SIZE +: ADDR_SIZE];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req),
        .ptr    (arb_ptr),
        .idx    (arb_idx),
        .onehot (arb_oh),
        .valid  (arb_any)
    );

    // next state and next registered outputs; RESP also samples so beats can follow with one gap cycle
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        win_n       = win;
        we_n        = we_q;
        wdata_n     = wdata_q;
        cnt_n       = cnt;
        gnt_n       = '0;
        rsp_valid_n = '0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        din_n       = ram_din;
        rx_valid_n  = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (state == RESP) ptr_n = ptr_inc;
                state_n = arb_any ? ADDR : IDLE;
                if (arb_any) begin
                    win_n      = arb_idx;
                    we_n       = req_we[arb_idx];
                    wdata_n    = req_wdata[arb_idx*DATA_W +: DATA_W];
                    gnt_n      = arb_oh;
                    din_n      = {req_we[arb_idx] ? CMD_WR_ADDR : CMD_RD_ADDR, DATA_W'(req_a)};
                    rx_valid_n = 1'b1;
                end
            end
            ADDR: begin
                din_n      = we_q ? {CMD_WR_DATA, wdata_q} : {CMD_RD_DATA, DATA_W'(0)};
                rx_valid_n = 1'b1;
                state_n    = DATA;
            end
            DATA: begin
                cnt_n   = '0;
                state_n = we_q ? RESP : WAIT_RD;
                if (we_q) begin
                    rsp_valid_n = win_oh;
                    rsp_err_n   = 1'b0;
                end
            end
            WAIT_RD: begin
                if (ram_tx_valid) begin
                    rsp_rdata_n = ram_dout;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = win_oh;
                    state_n     = RESP;
                end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = win_oh;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; the RAM shares rst_n so an aborted command needs no cleanup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt          <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            win          <= win_n;
            we_q         <= we_n;
            wdata_q      <= wdata_n;
            cnt          <= cnt_n;
            gnt          <= gnt_n;
            rsp_valid    <= rsp_valid_n;
            rsp_rdata    <= rsp_rdata_n;
            rsp_err      <= rsp_err_n;
            busy         <= (state_n != IDLE);
            ram_din      <= din_n;
            ram_rx_valid <= rx_valid_n;
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: transaction-level model plus behavioural RAM checking the arbiter
module tb_spi_ram_arbiter;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_we = '0;
    logic [NREQ*8-1:0] req_addr = '0;
    logic [NREQ*8-1:0] req_wdata = '0;
    logic [NREQ-1:0] gnt, rsp_valid;
    logic [7:0] rsp_rdata;
    logic rsp_err, busy, ram_rx_valid;
    logic [9:0] ram_din;
    logic ram_tx_valid = 1'b0;
    logic [7:0] ram_dout = 8'h00;

    int n_chk = 0;
    int n_pass = 0;
    int mp = 0;
    int rd_delay = 0;
    logic stray = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] last_rdata = 8'h00;
    int cd = 0;
    logic pend = 1'b0;
    logic [7:0] waddr = 8'h00;
    logic [7:0] raddr = 8'h00;
    int last_w = 0;

    spi_ram_arbiter #(.NUM_REQ(NREQ), .ADDR_SIZE(8), .RD_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_tx_valid (ram_tx_valid),
        .ram_dout     (ram_dout)
    );

    always #5 clk = ~clk;

    // behavioural spi_ram: decodes command beats, answers reads after rd_delay cycles (<0 = never)
    initial begin
        forever begin
            @(negedge clk);
            ram_tx_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (stray) begin
                    ram_tx_valid = 1'b1;
                    ram_dout = 8'hFF;
                    stray = 1'b0;
                end else if (pend) begin
                    if (cd == 0) begin
                        ram_tx_valid = 1'b1;
                        ram_dout = mem[raddr];
                        pend = 1'b0;
                    end else begin
                        cd--;
                    end
                end
                if (ram_rx_valid) begin
                    case (ram_din[9:8])
                        2'b00: waddr = ram_din[7:0];
                        2'b01: mem[waddr] = ram_din[7:0];
                        2'b10: raddr = ram_din[7:0];
                        default: begin
                            if (rd_delay >= 0) begin
                                pend = 1'b1;
                                cd = rd_delay;
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    // one complete transaction as the spec describes it; call with req set, returns in the response cycle
    task automatic txn();
        int w;
        int d;
        int n;
        logic wr;
        logic [7:0] a, wd, er;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (w < 0 && req[(mp + i) % NREQ]) w = (mp + i) % NREQ;
        end
        if (w < 0) return;
        wr = req_we[w];
        a = req_addr[w*8 +: 8];
        wd = req_wdata[w*8 +: 8];
        d = rd_delay;
        tick();
        chk("gnt", 32'(gnt), 32'(1) << w);
        chk("din_addr", 32'(ram_din), 32'({wr ? 2'b00 : 2'b10, a}));
        chk("rxv_addr", 32'(ram_rx_valid), 1);
        chk("busy", 32'(busy), 1);
        tick();
        chk("din_data", 32'(ram_din), 32'({wr ? 2'b01 : 2'b11, wr ? wd : 8'h00}));
        chk("rxv_data", 32'(ram_rx_valid), 1);
        chk("gnt_pulse", 32'(gnt), 0);
        if (wr) begin
            tick();
            chk("wr_rsp", 32'(rsp_valid), 32'(1) << w);
            chk("rxv_gap", 32'(ram_rx_valid), 0);
            exp_mem[a] = wd;
        end else begin
            n = (d < 0 || d > 15) ? 15 : d;
            for (int k = 0; k <= n; k++) begin
                tick();
                chk("rd_wait", 32'(rsp_valid), 0);
            end
            tick();
            er = (d >= 0 && d <= 15) ? exp_mem[a] : 8'h00;
            chk("rd_rsp", 32'(rsp_valid), 32'(1) << w);
            chk("rd_data", 32'(rsp_rdata), 32'(er));
            chk("rd_err", 32'(rsp_err), (d >= 0 && d <= 15) ? 0 : 1);
            chk("rxv_gap", 32'(ram_rx_valid), 0);
            last_rdata = er;
        end
        mp = (w + 1) % NREQ;
        last_w = w;
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_rxv", 32'(ram_rx_valid), 0);
        chk("rst_din", 32'(ram_din), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_req(0, 1'b1, 8'h12, 8'hA5);
        txn();
        req = '0;
        set_req(0, 1'b0, 8'h12, 8'h00);
        rd_delay = 0;
        txn();
        req = '0;
        set_req(0, 1'b0, 8'h20, 8'h00);
        rd_delay = -1;
        txn();
        req = '0;
        set_req(1, 1'b1, 8'h21, 8'h3C);
        txn();
        req = '0;
        set_req(0, 1'b1, 8'h30, 8'h5C);
        txn();
        req = '0;

        set_req(1, 1'b0, 8'h30, 8'h00);
        rd_delay = -1;
        tick();
        chk("abort_gnt", 32'(gnt), 32'b10);
        req = '0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt0", 32'(gnt), 0);
        chk("abort_rsp0", 32'(rsp_valid), 0);
        chk("abort_rdata0", 32'(rsp_rdata), 0);
        chk("abort_err0", 32'(rsp_err), 0);
        chk("abort_busy0", 32'(busy), 0);
        chk("abort_din0", 32'(ram_din), 0);
        chk("abort_rxv0", 32'(ram_rx_valid), 0);
        mp = 0;
        last_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | (|rsp_valid) | busy;
        end
        chk("abort_quiet", 32'(seen), 0);

        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 8'(8'h40 + 2 * k), 8'(8'hC0 + 2 * k));
            set_req(1, 1'b1, 8'(8'h41 + 2 * k), 8'(8'hC1 + 2 * k));
            txn();
            chk("rr_order", 32'(last_w), 32'(k % 2));
        end
        req = '0;
        set_req(0, 1'b0, 8'h41, 8'h00);
        rd_delay = 2;
        txn();
        req = '0;
        tick();
        stray = 1'b1;
        repeat (4) begin
            tick();
            chk("stray_rsp", 32'(rsp_valid), 0);
            chk("stray_rdata", 32'(rsp_rdata), 32'(last_rdata));
        end

        for (int it = 0; it < 60; it++) begin
            if (req == '0) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("idle_busy", 32'(busy), 0);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
                end
                if (req == '0)
                    set_req(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            end
            case ($urandom_range(0, 9))
                8: rd_delay = 15;
                9: rd_delay = 16;
                default: rd_delay = int'($urandom_range(0, 3));
            endcase
            txn();
            if ($urandom_range(0, 1) == 1)
                set_req(last_w, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            else
                req[last_w] = 1'b0;
        end
        req = '0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
